rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between three writeback sources: ALU, load/store unit (LSU) and multiply/divide unit (MDU).
- Per-source valid/ready handshake with fixed priority ALU > LSU > MDU, plus starvation promotion.
- The granted write is registered and driven to the register file, which commits it on the following negedge.
- Keeps a 32-bit pending-write scoreboard so decode can stall on RAW/WAW hazards against long-latency destinations.

Parameters:
- STARVE_LIMIT, 4: consecutive lost-arbitration cycles before LSU or MDU is promoted.
- CNT_W, 3: width of each starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU write request.
- alu_rd  in  5  ALU destination.
- alu_data  in  32  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid / lsu_rd / lsu_data / lsu_ready  in/in/in/out  1/5/32/1  LSU equivalents.
- mdu_valid / mdu_rd / mdu_data / mdu_ready  in/in/in/out  1/5/32/1  MDU equivalents.
- sb_set  in  1  decode issues a long-latency (LSU/MDU) op.
- sb_set_rd  in  5  destination of that op.
- rf_wr_en  out  1  register-file write enable.
- rf_rd  out  5  register-file write address.
- rf_wr_data  out  32  register-file write data.
- busy  out  32  pending-write bitmask; bit 0 is always 0.

Behaviour:
- Reset (async, rst_n=0):
  - rf_wr_en=0, rf_rd=0, rf_wr_data=0.
  - busy=0.
  - Both starvation counters=0.
  - Any in-flight accepted write is dropped; sources must re-present after reset.
- Handshake:
  - A source holds valid/rd/data stable until it sees ready=1.
  - A transfer occurs on a posedge when valid && ready.
  - Exactly one of the three ready outputs is 1 when any valid is 1; all are 0 otherwise.
  - ready is combinational from the valids and the urgent flags; it never depends on its own source's data.
- Grant order (highest first): MDU urgent, LSU urgent, ALU, LSU, MDU.
  - urgent = counter >= STARVE_LIMIT.
- Starvation counters (LSU and MDU each):
  - Increment when the source is valid and not granted, saturating at STARVE_LIMIT.
  - Clear to 0 when the source is granted or its valid is low.
- Output stage:
  - On a transfer, rf_wr_en<=(rd!=0), rf_rd<=rd, rf_wr_data<=data at that posedge.
  - With no transfer, rf_wr_en<=0; rf_rd and rf_wr_data hold.
  - Latency: accepted at posedge N, write visible at the register file during cycle N, committed at the negedge of cycle N, readable from the second half of cycle N.
  - Throughput: one write per cycle; the output never stalls.
- Writes to x0 are accepted (ready=1, counters update) but never assert rf_wr_en.
- Scoreboard, updated each posedge:
  - busy[sb_set_rd] is set when sb_set && sb_set_rd!=0.
  - busy[rd] is cleared when an LSU or MDU transfer with rd!=0 occurs.
  - ALU transfers never clear busy.
  - Simultaneous set and clear of the same rd in one cycle: set wins.
  - Set and clear of different rds in one cycle: both take effect.
  - busy[0] is hardwired 0.
- Setting an already-busy bit is legal (WAW); the first matching LSU/MDU write clears it.

Optional Feature:
- Macro: RF_WB_STARVE_GUARD_EN.
- Defined: starvation counters and urgent promotion exist as described above.
- Undefined:
  - Counters are removed, urgent is constant 0, and grant is pure fixed priority ALU > LSU > MDU.
  - STARVE_LIMIT and CNT_W are unused; all other behaviour is identical.

Test Plan:
- Reset mid-write: ALU valid, rd=5, data=0x1234, rst_n pulsed low between posedges -> rf_wr_en=0 and busy=0 immediately (asynchronously); nothing is written after release.
- Single ALU write: alu_valid, rd=3, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rf_wr_en=1, rf_rd=3, rf_wr_data=0xDEADBEEF; register 3 reads 0xDEADBEEF after that negedge.
- Priority: ALU rd=1 and LSU rd=2 valid together -> ALU granted first, LSU granted the following cycle; rf_rd sequence 1, 2; lsu_ready=0 in the first cycle.
- Starvation (macro defined, STARVE_LIMIT=4): ALU continuously valid, MDU valid with rd=9 -> mdu_ready=0 for 4 cycles, 1 in the 5th; ALU is stalled exactly that cycle. With the macro undefined, the MDU never wins while ALU stays valid.
- Scoreboard:
  - sb_set rd=7 -> busy=0x00000080 next cycle.
  - ALU write rd=7 -> busy unchanged.
  - LSU write rd=7 -> busy=0.
  - Same-cycle sb_set rd=7 with LSU write rd=7 -> busy[7] stays 1.
- x0 handling: LSU valid with rd=0 -> lsu_ready=1, rf_wr_en stays 0; sb_set with rd=0 -> busy stays 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU/LSU/MDU share one write port, plus a pending-write scoreboard.
// Optional starvation promotion of LSU/MDU is built when RF_WB_STARVE_GUARD_EN is defined.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        sb_set,
  input  logic [4:0]  sb_set_rd,
  output logic        rf_wr_en,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wr_data,
  output logic [31:0] busy
);

  if (STARVE_LIMIT >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow to hold STARVE_LIMIT");
  end

  logic        lsu_urgent, mdu_urgent;
  logic        alu_gnt, lsu_gnt, mdu_gnt, xfer;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic [31:0] busy_q, busy_d;

`ifdef RF_WB_STARVE_GUARD_EN
  logic [CNT_W-1:0] lsu_cnt_q, lsu_cnt_d;
  logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;

  assign lsu_urgent = (lsu_cnt_q >= CNT_W'(STARVE_LIMIT));
  assign mdu_urgent = (mdu_cnt_q >= CNT_W'(STARVE_LIMIT));

  always_comb begin
    lsu_cnt_d = lsu_cnt_q;
    mdu_cnt_d = mdu_cnt_q;
    if (!lsu_valid || lsu_gnt)                 lsu_cnt_d = '0;
    else if (lsu_cnt_q < CNT_W'(STARVE_LIMIT)) lsu_cnt_d = lsu_cnt_q + 1'b1;
    if (!mdu_valid || mdu_gnt)                 mdu_cnt_d = '0;
    else if (mdu_cnt_q < CNT_W'(STARVE_LIMIT)) mdu_cnt_d = mdu_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsu_cnt_q <= '0;
      mdu_cnt_q <= '0;
    end else begin
      lsu_cnt_q <= lsu_cnt_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end
`else
  assign lsu_urgent = 1'b0;
  assign mdu_urgent = 1'b0;
`endif

  // Promoted sources outrank the ALU; otherwise plain ALU > LSU > MDU.
  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    mdu_gnt = 1'b0;
    if (mdu_valid && mdu_urgent)      mdu_gnt = 1'b1;
    else if (lsu_valid && lsu_urgent) lsu_gnt = 1'b1;
    else if (alu_valid)               alu_gnt = 1'b1;
    else if (lsu_valid)               lsu_gnt = 1'b1;
    else if (mdu_valid)               mdu_gnt = 1'b1;
  end

  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;
  assign mdu_ready = mdu_gnt;
  assign xfer      = alu_gnt | lsu_gnt | mdu_gnt;

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (lsu_gnt) begin
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
    end else if (mdu_gnt) begin
      sel_rd   = mdu_rd;
      sel_data = mdu_data;
    end
  end

  always_comb begin
    wr_en_d = 1'b0;
    rd_d    = rd_q;
    data_d  = data_q;
    if (xfer) begin
      wr_en_d = (sel_rd != 5'd0);
      rd_d    = sel_rd;
      data_d  = sel_data;
    end
  end

  // Clear is applied before set so a same-cycle set of the same rd wins.
  always_comb begin
    busy_d = busy_q;
    if ((lsu_gnt || mdu_gnt) && sel_rd != 5'd0) busy_d[sel_rd] = 1'b0;
    if (sb_set && sb_set_rd != 5'd0)            busy_d[sb_set_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      busy_q  <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_wr_en   = wr_en_q;
  assign rf_rd      = rd_q;
  assign rf_wr_data = data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter; starvation expectations follow RF_WB_STARVE_GUARD_EN.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, mdu_valid = 1'b0, sb_set = 1'b0;
  logic [4:0]  alu_rd = '0, lsu_rd = '0, mdu_rd = '0, sb_set_rd = '0;
  logic [31:0] alu_data = '0, lsu_data = '0, mdu_data = '0;
  logic        alu_ready, lsu_ready, mdu_ready, rf_wr_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wr_data, busy;
  logic [31:0] rf_model [32];
  int          n_vec = 0;
  int          n_err = 0;
  logic        exp_mdu;

  rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .sb_set(sb_set), .sb_set_rd(sb_set_rd),
    .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_wr_data(rf_wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file commits on the negedge of the cycle the write is presented.
  always @(negedge clk) if (rf_wr_en) rf_model[rf_rd] <= rf_wr_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    #2;
    chk("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("rst_rd", {27'd0, rf_rd}, 32'd0);
    chk("rst_data", rf_wr_data, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_ready", {29'd0, alu_ready, lsu_ready, mdu_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single ALU write
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
    #1;
    chk("alu_ready", {29'd0, alu_ready, lsu_ready, mdu_ready}, 32'b100);
    tick();
    alu_valid = 1'b0;
    chk("alu_wr_en", {31'd0, rf_wr_en}, 32'd1);
    chk("alu_rd", {27'd0, rf_rd}, 32'd3);
    chk("alu_data", rf_wr_data, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("rf_x3", rf_model[3], 32'hDEADBEEF);
    tick();
    chk("idle_wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("idle_rd_hold", {27'd0, rf_rd}, 32'd3);
    chk("idle_data_hold", rf_wr_data, 32'hDEADBEEF);

    // ALU beats LSU, LSU follows
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
    #1;
    chk("prio_c1_ready", {29'd0, alu_ready, lsu_ready, mdu_ready}, 32'b100);
    tick();
    alu_valid = 1'b0;
    chk("prio_rd1", {27'd0, rf_rd}, 32'd1);
    #1;
    chk("prio_c2_ready", {29'd0, alu_ready, lsu_ready, mdu_ready}, 32'b010);
    tick();
    lsu_valid = 1'b0;
    chk("prio_rd2", {27'd0, rf_rd}, 32'd2);
    chk("prio_data2", rf_wr_data, 32'h22);
    chk("prio_wr_en2", {31'd0, rf_wr_en}, 32'd1);

    // scoreboard
    sb_set = 1'b1; sb_set_rd = 5'd7;
    tick();
    sb_set = 1'b0;
    chk("sb_set7", busy, 32'h80);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    tick();
    alu_valid = 1'b0;
    chk("sb_alu_keeps", busy, 32'h80);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h70;
    tick();
    lsu_valid = 1'b0;
    chk("sb_lsu_clears", busy, 32'h0);
    sb_set = 1'b1; sb_set_rd = 5'd7;
    lsu_valid = 1'b1; lsu_rd = 5'd7;
    tick();
    sb_set = 1'b0; lsu_valid = 1'b0;
    chk("sb_set_wins", busy, 32'h80);
    sb_set = 1'b1; sb_set_rd = 5'd4;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h99;
    tick();
    sb_set = 1'b0; mdu_valid = 1'b0;
    chk("sb_set4_clr7", busy, 32'h10);
    chk("mdu_rd7", {27'd0, rf_rd}, 32'd7);
    lsu_valid = 1'b1; lsu_rd = 5'd4;
    tick();
    lsu_valid = 1'b0;
    chk("sb_clr4", busy, 32'h0);

    // x0
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h5;
    #1;
    chk("x0_ready", {29'd0, alu_ready, lsu_ready, mdu_ready}, 32'b010);
    tick();
    lsu_valid = 1'b0;
    chk("x0_no_wr", {31'd0, rf_wr_en}, 32'd0);
    sb_set = 1'b1; sb_set_rd = 5'd0;
    tick();
    sb_set = 1'b0;
    chk("x0_no_busy", busy, 32'h0);

    // starvation: ALU always valid, MDU waiting
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
    for (int k = 1; k <= 6; k++) begin
      #1;
`ifdef RF_WB_STARVE_GUARD_EN
      exp_mdu = (k == 5);
`else
      exp_mdu = 1'b0;
`endif
      chk($sformatf("starve_c%0d", k), {29'd0, alu_ready, lsu_ready, mdu_ready},
          {29'd0, ~exp_mdu, 1'b0, exp_mdu});
      tick();
      if (exp_mdu) begin
        mdu_valid = 1'b0;
        chk("starve_rd9", {27'd0, rf_rd}, 32'd9);
      end
    end
    alu_valid = 1'b0; mdu_valid = 1'b0;
    tick();

    // asynchronous reset during an accepted write
    sb_set = 1'b1; sb_set_rd = 5'd3;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    sb_set = 1'b0; alu_valid = 1'b0;
    chk("pre_rst_wr_en", {31'd0, rf_wr_en}, 32'd1);
    chk("pre_rst_busy", busy, 32'h8);
    #1 rst_n = 1'b0;
    #1;
    chk("async_wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("async_busy", busy, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("rf_x5_untouched", rf_model[5], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
